audio_out_interp: RTL and testbench

AUDIO_OUT_INTERP -- requirements
Module: audio_out_interp

---
 rtl/audio_out_interp_if.sv | 22 ++
 rtl/audio_out_interp.sv | 95 +++++++++
 tb/tb_audio_out_interp.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/audio_out_interp_if.sv
// audio_out_interp_if: sample stream, output-rate tick and DAC-side output of audio_out_interp
//   din          : signed sample offered by the voice/mixer stage
//   din_valid    : din is offered this cycle
//   din_ready    : FIFO can accept (push when din_valid && din_ready)
//   sample_tick  : one-cycle output-rate strobe that pops the next target
//   dout         : signed sample for the PDM DAC
//   underrun     : sticky, set by a tick that finds the FIFO empty
//   underrun_clr : synchronous clear of underrun
//   master = sample producer / tick source, slave = audio_out_interp
interface audio_out_interp_if #(
    parameter int DATA_BITS = 12
);
    logic [DATA_BITS-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 sample_tick;
    logic [DATA_BITS-1:0] dout;
    logic                 underrun;
    logic                 underrun_clr;
    modport master (output din, din_valid, sample_tick, underrun_clr, input din_ready, dout, underrun);
    modport slave (input din, din_valid, sample_tick, underrun_clr, output din_ready, dout, underrun);
endinterface

// File: rtl/audio_out_interp.sv
// audio_out_interp: sample FIFO feeding a PDM DAC, with optional linear ramp between samples
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   io  : audio_out_interp_if.slave (din/din_valid/din_ready, sample_tick, dout, underrun/underrun_clr)
//   Macro AUDIO_OUT_INTERP_EN: defined -> 2^RAMP_BITS-cycle linear ramp to each new target;
//   undefined -> zero-order hold, dout = target one clk after the pop.
module audio_out_interp #(
    parameter int DATA_BITS = 12,
    parameter int FIFO_AW   = 2,
    parameter int RAMP_BITS = 4
) (
    input logic               clk,
    input logic               rst,
    audio_out_interp_if.slave io
);
    localparam int DEPTH = 1 << FIFO_AW;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;
    // count never exceeds DEPTH, so its MSB alone flags full
    assign full         = count[FIFO_AW];
    assign empty        = count == '0;
    assign push         = io.din_valid & ~full;
    assign pop          = io.sample_tick & ~empty;
    assign head         = mem[rd_ptr];
    assign io.din_ready = ~full;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= io.din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_AW'(push);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            count  <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) io.underrun <= 1'b0;
        else io.underrun <= io.underrun_clr ? 1'b0 : (io.sample_tick & empty) ? 1'b1 : io.underrun;
`ifdef AUDIO_OUT_INTERP_EN
    localparam int AW = DATA_BITS + RAMP_BITS + 1;
    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
    state_t               state_q, state_d;
    logic [AW-1:0]        acc, acc_base, diff_ext;
    logic [DATA_BITS:0]   diff, diff_new;
    logic [RAMP_BITS-1:0] cnt;
    // difference fits in DATA_BITS+1 bits, so modular subtraction of the sign-extended operands is exact
    assign diff_new = {head[DATA_BITS-1], head} - {io.dout[DATA_BITS-1], io.dout};
    assign acc_base = {io.dout[DATA_BITS-1], io.dout, {RAMP_BITS{1'b0}}};
    assign diff_ext = {{RAMP_BITS{diff[DATA_BITS]}}, diff};
    // every ramp point lies between two legal samples, so the slice never overflows
    assign io.dout  = acc[RAMP_BITS+DATA_BITS-1:RAMP_BITS];
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (pop) state_d = RAMP;
        else if (state_q == RAMP && cnt == '1) state_d = HOLD;
    end
    // the pop edge performs the first of the 2^RAMP_BITS additions so the first step shows one clk after the tick
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc  <= '0;
            diff <= '0;
            cnt  <= '0;
        end else if (pop) begin
            acc  <= acc_base + {{RAMP_BITS{diff_new[DATA_BITS]}}, diff_new};
            diff <= diff_new;
            cnt  <= RAMP_BITS'(1);
        end else if (state_q == RAMP) begin
            acc <= acc + diff_ext;
            cnt <= cnt + RAMP_BITS'(1);
        end
`else
    typedef enum logic {IDLE, HOLD} state_t;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] dout_q;
    assign io.dout = dout_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (pop) state_d = HOLD;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) dout_q <= '0;
        else if (pop) dout_q <= head;
`endif
endmodule

// File: tb/tb_audio_out_interp.sv
// tb_audio_out_interp: randomized and directed scoreboard bench for audio_out_interp
module tb_audio_out_interp;
    localparam int DB    = 12;
    localparam int FA    = 2;
    localparam int RB    = 4;
    localparam int DEPTH = 1 << FA;
    localparam int STEPS = 1 << RB;
    typedef struct {
        logic [DB-1:0] dout;
        logic          ready;
        logic          urun;
    } exp_t;
    logic  clk = 1'b0;
    logic  rst = 1'b1;
    exp_t  sb[$];
    int    checks = 0;
    int    passes = 0;
    string phase = "reset";
    // reference model: FIFO contents as integers, and the ramp as start/target/elapsed cycles
    int    fq[$];
    int    ramp_s = 0;
    int    ramp_g = 0;
    int    ramp_k = 0;
    bit    started = 0;
    bit    m_urun = 0;
    audio_out_interp_if #(.DATA_BITS(DB)) io ();
    audio_out_interp #(.DATA_BITS(DB), .FIFO_AW(FA), .RAMP_BITS(RB)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;
    function automatic int sx(input logic [DB-1:0] v);
        return int'($signed(v));
    endfunction
    // straight line from start to target over STEPS cycles, floored
    function automatic int model_dout();
        int num;
        if (!started) return 0;
        if (ramp_k >= STEPS) return ramp_g;
`ifdef AUDIO_OUT_INTERP_EN
        num = ramp_s * STEPS + ramp_k * (ramp_g - ramp_s);
        return num >>> RB;
`else
        num = 0;
        return ramp_g + num;
`endif
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", name, phase, act, exp);
    endtask
    task automatic step(input bit v, input int d, input bit t, input bit c);
        int cur;
        bit pop, push;
        @(negedge clk);
        io.din = DB'(d);
        io.din_valid = v;
        io.sample_tick = t;
        io.underrun_clr = c;
        cur  = model_dout();
        pop  = t && fq.size() > 0;
        push = v && fq.size() < DEPTH;
        if (c) m_urun = 0;
        else if (t && fq.size() == 0) m_urun = 1;
        if (pop) begin
            ramp_s  = cur;
            ramp_g  = fq.pop_front();
            ramp_k  = 1;
            started = 1;
        end else if (started && ramp_k < STEPS) ramp_k++;
        if (push) fq.push_back(sx(DB'(d)));
        sb.push_back('{dout: DB'(model_dout()), ready: fq.size() < DEPTH, urun: m_urun});
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask
    task automatic model_reset();
        io.din_valid = 0;
        io.sample_tick = 0;
        io.underrun_clr = 0;
        fq.delete();
        started = 0;
        ramp_k = 0;
        m_urun = 0;
        sb.push_back('{dout: '0, ready: 1'b1, urun: 1'b0});
    endtask
    // asserts rst between clock edges; when asked, checks the outputs before any edge arrives
    task automatic apply_reset(input bit check_now);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        if (check_now) begin
            chk("async_rst_dout", int'(io.dout), 0);
            chk("async_rst_ready", int'(io.din_ready), 1);
            chk("async_rst_underrun", int'(io.underrun), 0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dout", int'(io.dout), int'(e.dout));
            chk("din_ready", int'(io.din_ready), int'(e.ready));
            chk("underrun", int'(io.underrun), int'(e.urun));
        end
    end
    initial begin
        io.din = '0;
        io.din_valid = 0;
        io.sample_tick = 0;
        io.underrun_clr = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        phase = "ramp_0_to_100";
        step(1, 'h100, 0, 0);
        step(0, 0, 1, 0);
        idle(18);
        phase = "underrun_hold";
        step(0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 1);
        phase = "fill_full";
        step(1, 'h7FF, 0, 0);
        step(1, 'h800, 0, 0);
        step(1, 'h100, 0, 0);
        step(1, 'h000, 0, 0);
        step(1, 'h555, 0, 0);
        phase = "tick_push_full";
        step(1, 'h666, 1, 0);
        idle(17);
        phase = "ramp_7ff_to_800";
        step(0, 0, 1, 0);
        idle(17);
        phase = "tick_push_nonfull";
        step(1, 'h333, 1, 0);
        idle(3);
        phase = "underrun_clr_wins";
        apply_reset(0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        phase = "retrigger";
        step(1, 'h100, 0, 0);
        step(1, 'h000, 0, 0);
        step(0, 0, 1, 0);
        idle(7);
        step(0, 0, 1, 0);
        idle(17);
        phase = "async_reset";
        step(1, 'h400, 0, 0);
        step(1, 'h010, 1, 0);
        step(1, 'h020, 0, 0);
        step(1, 'h030, 0, 0);
        step(1, 'h040, 0, 0);
        step(1, 'h050, 0, 0);
        apply_reset(1);
        phase = "zoh_or_ramp_after_reset";
        step(1, 'h9AB, 0, 0);
        step(0, 0, 1, 0);
        idle(17);
        phase = "random";
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
        idle(2);
        @(posedge clk);
        #2;
        phase = "end";
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
